// File: rtl/mem_addr_unit_pkg.sv
// Shared definitions for the memory address stage: memory command encoding
// and default address-map constants.
package mem_addr_unit_pkg;

  typedef enum logic [1:0] {
    MNONE    = 2'b00,
    MREAD    = 2'b01,
    MILLEGAL = 2'b10,
    MWRITE   = 2'b11
  } mem_cmd_e;

  localparam int           DEF_ADDR_W   = 9;
  localparam int           DEF_DATA_W   = 16;
  localparam logic [8:0]   DEF_LED_ADDR = 9'h100;
  localparam logic [8:0]   DEF_SW_ADDR  = 9'h140;

endpackage

// File: rtl/mem_addr_unit_if.sv
// Controller strobes and RAM bus between the CPU controller/RAM side (master)
// and the memory address stage (slave).
interface mem_addr_unit_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic [1:0]        mem_cmd;
  logic              reset_pc;
  logic              load_pc;
  logic              addr_sel;
  logic              load_addr;
  logic              load_ir;
  logic [ADDR_W-1:0] mem_addr;
  logic              ram_write;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] read_data;

  modport master (
    output mem_cmd, reset_pc, load_pc, addr_sel, load_addr, load_ir, read_data,
    input  mem_addr, ram_write, ram_din
  );

  modport slave (
    input  mem_cmd, reset_pc, load_pc, addr_sel, load_addr, load_ir, read_data,
    output mem_addr, ram_write, ram_din
  );
endinterface

// File: rtl/mem_addr_unit_dffe.sv
// Load-enable register with synchronous active-high clear; used for pc,
// data_addr, ir and the LED register.
module mem_addr_unit_dffe #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/mem_addr_unit.sv
// Memory-side stage behind the CPU controller: PC, data address and IR registers,
// RAM address/write strobe generation and memory-mapped LED/switch decode.
module mem_addr_unit
  import mem_addr_unit_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(DEF_LED_ADDR),
  parameter logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(DEF_SW_ADDR)
) (
  input  logic                clk,
  input  logic                reset,
  mem_addr_unit_if.slave      bus,
  input  logic [DATA_W-1:0]   datapath_out,
  input  logic [7:0]          switches,
  output logic [DATA_W-1:0]   mdata,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   ir,
  output logic [2:0]          opcode,
  output logic [1:0]          op,
  output logic [7:0]          leds,
  output logic                mem_err
);

  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] data_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              is_read;
  logic              is_write;
  logic              ram_space;
  logic              led_en;

  assign pc_next = bus.reset_pc ? '0 : pc + 1'b1;

  mem_addr_unit_dffe #(.N(ADDR_W)) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (bus.load_pc),
    .d     (pc_next),
    .q     (pc)
  );

  mem_addr_unit_dffe #(.N(ADDR_W)) u_data_addr (
    .clk   (clk),
    .reset (reset),
    .en    (bus.load_addr),
    .d     (datapath_out[ADDR_W-1:0]),
    .q     (data_addr)
  );

  // ir captures the mdata formed from the pre-edge address, so a fetch needs
  // no extra pipeline stage beyond the RAM's own read latency.
  mem_addr_unit_dffe #(.N(DATA_W)) u_ir (
    .clk   (clk),
    .reset (reset),
    .en    (bus.load_ir),
    .d     (mdata),
    .q     (ir)
  );

  mem_addr_unit_dffe #(.N(8)) u_leds (
    .clk   (clk),
    .reset (reset),
    .en    (led_en),
    .d     (datapath_out[7:0]),
    .q     (leds)
  );

  assign mem_addr  = bus.addr_sel ? pc : data_addr;
  assign is_read   = (bus.mem_cmd == MREAD);
  assign is_write  = (bus.mem_cmd == MWRITE);
  assign ram_space = ~mem_addr[ADDR_W-1];
  assign led_en    = is_write && (mem_addr == LED_ADDR);

  assign bus.mem_addr  = mem_addr;
  assign bus.ram_din   = datapath_out;
  assign bus.ram_write = is_write && ram_space && !reset;

  always_comb begin
    mdata = '0;
    if (is_read) begin
      if (mem_addr == SW_ADDR)
        mdata[7:0] = switches;
      else if (ram_space)
        mdata = bus.read_data;
    end
  end

  assign opcode = ir[DATA_W-1 -: 3];
  assign op     = ir[DATA_W-4 -: 2];

  // Sticky: only a reset clears an illegal-command report.
  always_ff @(posedge clk) begin
    if (reset)
      mem_err <= 1'b0;
    else if (bus.mem_cmd == MILLEGAL)
      mem_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_addr_unit.sv
// Self-checking bench for mem_addr_unit: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_mem_addr_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] datapath_out;
  logic [7:0]  switches;
  logic [15:0] mdata;
  logic [8:0]  pc;
  logic [15:0] ir;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [7:0]  leds;
  logic        mem_err;

  mem_addr_unit_if #(.ADDR_W(9), .DATA_W(16)) bus ();

  mem_addr_unit dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .datapath_out (datapath_out),
    .switches     (switches),
    .mdata        (mdata),
    .pc           (pc),
    .ir           (ir),
    .opcode       (opcode),
    .op           (op),
    .leds         (leds),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Synchronous RAM with one cycle read latency (read-before-write)
  logic [15:0] ram [512];
  logic [15:0] rd_q = 16'h0;
  assign bus.read_data = rd_q;

  // Behavioural model state
  logic [8:0]  m_pc   = '0;
  logic [8:0]  m_da   = '0;
  logic [15:0] m_ir   = '0;
  logic [7:0]  m_leds = '0;
  logic        m_err  = 1'b0;

  function automatic logic [15:0] exp_mdata(logic [1:0] cmd, logic [8:0] a,
                                            logic [15:0] rd, logic [7:0] sw);
    if (cmd != 2'b01) return 16'h0;
    if (a == 9'h140)  return {8'h00, sw};
    if (a < 9'h100)   return rd;
    return 16'h0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [8:0]  a;
    logic [15:0] md;
    a  = bus.addr_sel ? m_pc : m_da;
    md = exp_mdata(bus.mem_cmd, a, rd_q, switches);
    if (reset) begin
      m_pc = '0; m_da = '0; m_ir = '0; m_leds = '0; m_err = 1'b0;
    end else begin
      if (bus.load_ir)   m_ir = md;
      if (bus.load_addr) m_da = datapath_out[8:0];
      if (bus.load_pc)   m_pc = bus.reset_pc ? 9'h0 : 9'((int'(m_pc) + 1) % 512);
      if (bus.mem_cmd == 2'b11 && a == 9'h100) m_leds = datapath_out[7:0];
      if (bus.mem_cmd == 2'b10) m_err = 1'b1;
    end
    rd_q <= ram[bus.mem_addr];
    if (bus.ram_write) ram[bus.mem_addr] <= bus.ram_din;
  end

  always @(negedge clk) begin
    logic [8:0] a;
    #4;
    if (cmp_en) begin
      a = bus.addr_sel ? m_pc : m_da;
      chk("mem_addr",  bus.mem_addr, a);
      chk("ram_write", bus.ram_write,
          bus.mem_cmd == 2'b11 && a < 9'h100 && !reset);
      chk("ram_din",   bus.ram_din, datapath_out);
      chk("mdata",     mdata, exp_mdata(bus.mem_cmd, a, rd_q, switches));
      chk("pc",        pc, m_pc);
      chk("ir",        ir, m_ir);
      chk("opcode",    opcode, m_ir[15:13]);
      chk("op",        op, m_ir[12:11]);
      chk("leds",      leds, m_leds);
      chk("mem_err",   mem_err, m_err);
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 16'($urandom);
    ram[0] = 16'hD105;

    reset = 1'b1; bus.load_pc = 1'b1; bus.reset_pc = 1'b1; bus.mem_cmd = 2'b11;
    bus.addr_sel = 1'b1; bus.load_addr = 1'b0; bus.load_ir = 1'b0;
    datapath_out = 16'h0; switches = 8'h0;

    // Reset, with a write pending to address 0 that must not reach the RAM
    @(negedge clk); @(negedge clk);
    #2;
    chk("rst_pc",        pc, 9'h0);
    chk("rst_ir",        ir, 16'h0);
    chk("rst_leds",      leds, 8'h0);
    chk("rst_mem_err",   mem_err, 1'b0);
    chk("rst_ram_write", bus.ram_write, 1'b0);
    cmp_en = 1'b1;

    // PC count up to 0x1FF and wrap
    reset = 1'b0; bus.mem_cmd = 2'b00; bus.reset_pc = 1'b0; bus.load_pc = 1'b1;
    repeat (511) @(negedge clk);
    #2 chk("pc_top", pc, 9'h1FF);
    @(negedge clk);
    #2 chk("pc_wrap", pc, 9'h0);
    bus.load_pc = 1'b0;

    // Fetch from address 0 with IR and PC loaded on the same edge
    @(negedge clk);
    bus.addr_sel = 1'b1; bus.mem_cmd = 2'b01;
    @(negedge clk);
    bus.load_ir = 1'b1; bus.load_pc = 1'b1;
    #2 chk("fetch_mdata", mdata, 16'hD105);
    @(negedge clk);
    bus.load_ir = 1'b0; bus.load_pc = 1'b0; bus.mem_cmd = 2'b00;
    #2;
    chk("fetch_ir",     ir, 16'hD105);
    chk("fetch_opcode", opcode, 3'b110);
    chk("fetch_op",     op, 2'b10);
    chk("fetch_pc",     pc, 9'h001);

    // Store into RAM space, then to the LED address
    @(negedge clk);
    bus.addr_sel = 1'b0; datapath_out = 16'h0042; bus.load_addr = 1'b1;
    @(negedge clk);
    bus.load_addr = 1'b0; bus.mem_cmd = 2'b11;
    #2;
    chk("st_addr",  bus.mem_addr, 9'h042);
    chk("st_write", bus.ram_write, 1'b1);
    @(negedge clk);
    bus.mem_cmd = 2'b00; datapath_out = 16'h0100; bus.load_addr = 1'b1;
    @(negedge clk);
    bus.load_addr = 1'b0; bus.mem_cmd = 2'b11;
    #2 chk("st_hi_write", bus.ram_write, 1'b0);
    @(negedge clk);
    datapath_out = 16'h00A5;
    @(negedge clk);
    #2 chk("led_write", leds, 8'hA5);

    // Switch read, and a write to the switch address that must be ignored
    bus.mem_cmd = 2'b00; datapath_out = 16'h0140; bus.load_addr = 1'b1;
    @(negedge clk);
    bus.load_addr = 1'b0; switches = 8'h3C; bus.mem_cmd = 2'b01;
    #2 chk("sw_read", mdata, 16'h003C);
    @(negedge clk);
    bus.mem_cmd = 2'b11; datapath_out = 16'h0077;
    #2 chk("sw_write_ram", bus.ram_write, 1'b0);
    @(negedge clk);
    bus.mem_cmd = 2'b00;
    #2 chk("sw_write_leds", leds, 8'hA5);

    // Illegal command on a RAM-space address
    @(negedge clk);
    bus.addr_sel = 1'b1; bus.mem_cmd = 2'b10;
    #2;
    chk("ill_write", bus.ram_write, 1'b0);
    chk("ill_mdata", mdata, 16'h0);
    @(negedge clk);
    bus.mem_cmd = 2'b00;
    #2 chk("ill_err", mem_err, 1'b1);
    repeat (5) @(negedge clk);
    #2 chk("ill_sticky", mem_err, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2 chk("ill_cleared", mem_err, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      int c;
      @(negedge clk);
      reset         = ($urandom_range(0, 63) == 0);
      bus.load_pc   = $urandom_range(0, 1) == 1;
      bus.reset_pc  = ($urandom_range(0, 7) == 0);
      bus.addr_sel  = $urandom_range(0, 1) == 1;
      bus.load_addr = ($urandom_range(0, 3) == 0);
      bus.load_ir   = ($urandom_range(0, 2) == 0);
      switches      = 8'($urandom);
      c = $urandom_range(0, 99);
      bus.mem_cmd   = (c < 2) ? 2'b10 : (c < 30) ? 2'b00 : (c < 65) ? 2'b01 : 2'b11;
      datapath_out  = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      datapath_out[8:0] = 9'h100;
      else if (sel == 1) datapath_out[8:0] = 9'h140;
      else if (sel == 2) datapath_out[8] = 1'b1;
      else               datapath_out[8] = 1'b0;
    end
    @(negedge clk);
    #2;
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
